pipe_stage_elastic: RTL and testbench

Parametrised, elastic successor to the fixed inter-stage pipeline registers. It carries a control bundle and a data bundle through DEPTH register slots under a valid/ready handshake. It supports global stall, synchronous flush with bubble insertion, bubble collapsing and an occupancy count. It sits between any two processor stages (ID/EXE, EXE/MEM, MEM/WB) and lets hazard logic hold or kill in-flight instructions without per-register glue.

---
 rtl/pipe_stage_elastic.sv | 123 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic DEPTH-slot pipeline register carrying a control and data bundle under valid/ready,
// with stall, flush and bubble collapsing. Define PIPE_STAGE_CLR_DATA_EN to zero data on flush/bubble.
module pipe_stage_elastic #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 9,
   parameter int DEPTH  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CTRL_W-1:0]            in_ctrl,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CTRL_W-1:0]            out_ctrl,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  v;
   logic [DEPTH-1:0]  v_nxt;
   logic [DEPTH-1:0]  adv;
   logic [CTRL_W-1:0] ctrl     [DEPTH];
   logic [CTRL_W-1:0] ctrl_nxt [DEPTH];
   logic [DATA_W-1:0] data     [DEPTH];
   logic [DATA_W-1:0] data_nxt [DEPTH];
   logic [OCC_W-1:0]  occ_nxt;
   logic              take;

   // Control of a slot that receives a bubble always reads as all-zero.
   function automatic logic [CTRL_W-1:0] bubble_ctrl(input logic vld, input logic [CTRL_W-1:0] c);
      return vld ? c : '0;
   endfunction

   // Data seen by a slot receiving src; old value is kept on a bubble unless clearing is enabled.
   function automatic logic [DATA_W-1:0] bubble_data(input logic vld, input logic [DATA_W-1:0] src,
                                                     input logic [DATA_W-1:0] old);
`ifdef PIPE_STAGE_CLR_DATA_EN
      return vld ? src : '0;
`else
      return vld ? src : old;
`endif
   endfunction

   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
      logic [OCC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) cnt = cnt + OCC_W'(vec[i]);
      return cnt;
   endfunction

   // A slot may advance if it is empty or the slot after it advances.
   always_comb begin
      logic a;
      a = !v[DEPTH-1] | out_ready;
      adv = '0;
      adv[DEPTH-1] = a;
      for (int i = DEPTH-2; i >= 0; i--) begin
         a = !v[i] | a;
         adv[i] = a;
      end
   end

   assign in_ready  = adv[0] & !stall & !flush;
   assign out_valid = v[DEPTH-1] & !stall & !flush;
   assign out_ctrl  = bubble_ctrl(v[DEPTH-1], ctrl[DEPTH-1]);
   assign out_data  = data[DEPTH-1];
   assign take      = in_valid & in_ready;

   always_comb begin
      v_nxt = v;
      for (int i = 0; i < DEPTH; i++) begin
         ctrl_nxt[i] = ctrl[i];
         data_nxt[i] = data[i];
      end
      if (flush) begin
         v_nxt = '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_nxt[i] = '0;
            data_nxt[i] = bubble_data(1'b0, data[i], data[i]);
         end
      end else if (!stall) begin
         if (adv[0]) begin
            v_nxt[0]    = take;
            ctrl_nxt[0] = bubble_ctrl(take, in_ctrl);
            data_nxt[0] = bubble_data(take, in_data, data[0]);
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
               v_nxt[i]    = v[i-1];
               ctrl_nxt[i] = bubble_ctrl(v[i-1], ctrl[i-1]);
               data_nxt[i] = bubble_data(v[i-1], data[i-1], data[i]);
            end
         end
      end
      occ_nxt = popcount(v_nxt);
   end

   // Slot registers; occupancy is registered with v so it never lags the valid bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v         <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl[i] <= '0;
            data[i] <= '0;
         end
      end else begin
         v         <= v_nxt;
         occupancy <= occ_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            ctrl[i] <= ctrl_nxt[i];
            data[i] <= data_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic (DEPTH=2): reset, streaming, backpressure,
// bubble collapse, stall/flush and asynchronous reset mid-stream.
module tb_pipe_stage_elastic;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  in_ctrl;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_ctrl;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   int n_chk = 0;
   int n_err = 0;

   pipe_stage_elastic #(.DATA_W(32), .CTRL_W(9), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] mkctrl(input logic [7:0] d);
      return {1'b1, d};
   endfunction

   task automatic drive(input logic vld, input logic [7:0] d);
      in_valid = vld;
      in_data  = 32'(d);
      in_ctrl  = mkctrl(d);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] stream [4];
      stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;

      // Reset with an entry offered at the input.
      rst = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = 32'h0;
      tick; tick;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
      chk("rst_occ",       32'(occupancy), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Streaming: two-cycle latency, then one entry per cycle in order.
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k < 4) drive(1'b1, stream[k]);
         else       drive(1'b0, 8'h00);
         #1;
         if (k < 2) begin
            chk("str_empty", 32'(out_valid), 32'd0);
         end else begin
            chk("str_valid", 32'(out_valid), 32'd1);
            chk("str_data",  out_data, 32'(stream[k-2]));
            chk("str_ctrl",  32'(out_ctrl), 32'(mkctrl(stream[k-2])));
         end
         tick;
      end
      chk("str_drained", 32'(occupancy), 32'd0);

      // Backpressure: fill, hold, then release with same-cycle accept.
      out_ready = 1'b0;
      drive(1'b1, 8'hA0); tick;
      drive(1'b1, 8'hA1); tick;
      drive(1'b1, 8'hA2); #1;
      chk("bp_occ_full",  32'(occupancy), 32'd2);
      chk("bp_in_ready0", 32'(in_ready),  32'd0);
      chk("bp_head",      out_data,       32'hA0);
      out_ready = 1'b1; #1;
      chk("bp_in_ready1", 32'(in_ready),  32'd1);
      chk("bp_deliver0",  32'(out_valid), 32'd1);
      tick;
      drive(1'b0, 8'h00); #1;
      chk("bp_occ_kept",  32'(occupancy), 32'd2);
      chk("bp_deliver1",  out_data,       32'hA1);
      tick;
      chk("bp_deliver2",  out_data,       32'hA2);
      chk("bp_occ1",      32'(occupancy), 32'd1);
      tick;
      chk("bp_occ0",      32'(occupancy), 32'd0);

      // Bubble collapse: the idle cycle must not leave a hole in the chain.
      out_ready = 1'b0;
      drive(1'b1, 8'h55); tick;
      drive(1'b0, 8'h00); tick;
      chk("bc_occ1",  32'(occupancy), 32'd1);
      chk("bc_head",  out_data,       32'h55);
      drive(1'b1, 8'h66); tick;
      drive(1'b0, 8'h00); #1;
      chk("bc_occ2",  32'(occupancy), 32'd2);
      out_ready = 1'b1; #1;
      chk("bc_out0",  out_data,       32'h55);
      tick;
      chk("bc_out1",  out_data,       32'h66);
      chk("bc_vld1",  32'(out_valid), 32'd1);
      tick;
      chk("bc_empty", 32'(occupancy), 32'd0);

      // Stall freezes everything; flush then wins over stall and drops the input.
      out_ready = 1'b0;
      drive(1'b1, 8'h77); tick;
      drive(1'b1, 8'h78); tick;
      stall = 1'b1; out_ready = 1'b1; drive(1'b1, 8'h79); #1;
      for (int k = 0; k < 3; k++) begin
         chk("st_out_valid", 32'(out_valid), 32'd0);
         chk("st_in_ready",  32'(in_ready),  32'd0);
         chk("st_occ",       32'(occupancy), 32'd2);
         chk("st_ctrl",      32'(out_ctrl),  32'(mkctrl(8'h77)));
         tick;
      end
      flush = 1'b1; #1;
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      tick;
      flush = 1'b0; stall = 1'b0; drive(1'b0, 8'h00); #1;
      chk("fl_occ",       32'(occupancy), 32'd0);
      chk("fl_out_ctrl",  32'(out_ctrl),  32'd0);
      chk("fl_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_STAGE_CLR_DATA_EN
      chk("fl_out_data",  out_data,       32'd0);
`endif

      // Asynchronous reset between edges with two entries in flight.
      out_ready = 1'b0;
      drive(1'b1, 8'h91); tick;
      drive(1'b1, 8'h92); tick;
      drive(1'b0, 8'h00);
      chk("ar_occ_before", 32'(occupancy), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("ar_occ",       32'(occupancy), 32'd0);
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_out_ctrl",  32'(out_ctrl),  32'd0);
      #1 rst = 1'b0;
      out_ready = 1'b1; drive(1'b1, 8'hB1); #1;
      chk("ar_in_ready", 32'(in_ready), 32'd1);
      tick;
      drive(1'b0, 8'h00);
      chk("ar_accept", 32'(occupancy), 32'd1);
      tick;
      chk("ar_deliver", out_data, 32'hB1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
